// File: rtl/change_dispenser.sv
// ============================================================================
// change_dispenser : vend pulse, then greedy dime/nickel pulses to the hopper
// Revision 1.0
// ============================================================================
`default_nettype none

module change_dispenser #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic       soda_i,
    input  logic [2:0] change_i,
    input  logic       hopper_ready_i,
    output logic       vend_o,
    output logic       dime_o,
    output logic       nickel_o,
    output logic       busy_o,
    output logic       pending_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VEND   = 3'd1,
        S_DIME   = 3'd2,
        S_NICKEL = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    localparam logic [3:0] C_GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit         C_NO_GAP   = (GAP_CYCLES == 0);

    state_t     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       pend_v_q, pend_v_d;
    logic [2:0] pend_amt_q, pend_amt_d;
    logic       err_q, err_d;

    logic       w_bad_chg;
    logic [2:0] w_amt;

    function automatic state_t dispatch(input logic [2:0] r);
        if (r >= 3'd2)      return S_DIME;
        else if (r == 3'd1) return S_NICKEL;
        else                return S_IDLE;
    endfunction

    // Out-of-range change still vends, but pays nothing and flags the error.
    assign w_bad_chg = soda_i && (change_i > 3'd4);
    assign w_amt     = (change_i > 3'd4) ? 3'd0 : change_i;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        gap_cnt_d  = gap_cnt_q;
        pend_v_d   = pend_v_q;
        pend_amt_d = pend_amt_q;
        err_d      = err_q | w_bad_chg;

        if (state_q == S_IDLE) begin
            if (pend_v_q) begin
                rem_d    = pend_amt_q;
                pend_v_d = 1'b0;
                state_d  = S_VEND;
                if (soda_i) begin
                    pend_v_d   = 1'b1;
                    pend_amt_d = w_amt;
                end
            end else if (soda_i) begin
                rem_d   = w_amt;
                state_d = S_VEND;
            end
        end else if (soda_i) begin
            if (!pend_v_q) begin
                pend_v_d   = 1'b1;
                pend_amt_d = w_amt;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_VEND: state_d = dispatch(rem_q);
            S_DIME: begin
                if (hopper_ready_i) begin
                    rem_d = rem_q - 3'd2;
                    if (C_NO_GAP) begin
                        state_d = dispatch(rem_q - 3'd2);
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = C_GAP_LOAD;
                    end
                end
            end
            S_NICKEL: begin
                if (hopper_ready_i) begin
                    rem_d = rem_q - 3'd1;
                    if (C_NO_GAP) begin
                        state_d = dispatch(rem_q - 3'd1);
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = C_GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) state_d   = dispatch(rem_q);
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rem_q      <= 3'd0;
            gap_cnt_q  <= 4'd0;
            pend_v_q   <= 1'b0;
            pend_amt_q <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            gap_cnt_q  <= gap_cnt_d;
            pend_v_q   <= pend_v_d;
            pend_amt_q <= pend_amt_d;
            err_q      <= err_d;
        end
    end

    // Coin pulses follow the hopper handshake in the same cycle.
    assign vend_o    = (state_q == S_VEND);
    assign dime_o    = (state_q == S_DIME) && hopper_ready_i;
    assign nickel_o  = (state_q == S_NICKEL) && hopper_ready_i;
    assign busy_o    = (state_q != S_IDLE);
    assign pending_o = pend_v_q;
    assign err_o     = err_q;

endmodule

`default_nettype wire
